// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO register file
// Optional build macro: MUL_DIV_FAST_MULT_EN (single-cycle multiplier instead of shift-add).
module mul_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        hi_write_enable,
   output logic        lo_write_enable
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t      state, state_next;
   logic [5:0]  count, count_next;
   logic        is_signed, sign_a, sign_b;
   logic [31:0] mag_a, mag_b;
   logic [63:0] acc, acc_next;
   logic [31:0] hi_next, lo_next;
   logic        load_result;
   logic        accept;

   logic [31:0] abs_a, abs_b, a_raw, quot_fix, rem_fix;
   logic [32:0] div_diff;
   logic [63:0] div_step;
   logic        neg_result;

   // op[0]=0 selects the signed variants (MULT, DIV)
   assign abs_a      = (!op[0] && a[31]) ? -a : a;
   assign abs_b      = (!op[0] && b[31]) ? -b : b;
   assign neg_result = is_signed & (sign_a ^ sign_b);
   assign a_raw      = (is_signed && sign_a) ? -mag_a : mag_a;

   // Restoring division: acc holds {remainder, dividend/quotient bits}
   assign div_diff = acc[63:31] - {1'b0, mag_b};
   assign div_step = div_diff[32] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
   assign quot_fix = neg_result ? -acc[31:0] : acc[31:0];
   assign rem_fix  = (is_signed && sign_a) ? -acc[63:32] : acc[63:32];

`ifdef MUL_DIV_FAST_MULT_EN
   logic [63:0] fast_prod;
   assign fast_prod = {32'd0, mag_a} * {32'd0, mag_b};
`else
   logic [32:0] mul_sum;
   logic [63:0] mul_step;
   // Shift-add: acc holds {partial product, remaining multiplier bits}
   assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
   assign mul_step = {mul_sum, acc[31:1]};
`endif

   always_comb begin
      state_next  = state;
      count_next  = count;
      acc_next    = acc;
      hi_next     = hi_out;
      lo_next     = lo_out;
      load_result = 1'b0;
      accept      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               count_next = 6'd0;
               state_next = op[1] ? S_DIV : S_MUL;
               acc_next   = op[1] ? {32'd0, abs_a} : {32'd0, abs_b};
            end
         end
         S_MUL: begin
`ifdef MUL_DIV_FAST_MULT_EN
            {hi_next, lo_next} = neg_result ? -fast_prod : fast_prod;
            load_result = 1'b1;
            state_next  = S_DONE;
`else
            if (count == 6'd32) begin
               {hi_next, lo_next} = neg_result ? -acc : acc;
               load_result = 1'b1;
               state_next  = S_DONE;
            end else begin
               acc_next   = mul_step;
               count_next = count + 6'd1;
            end
`endif
         end
         S_DIV: begin
            if (mag_b == 32'd0) begin
               hi_next     = a_raw;
               lo_next     = 32'hFFFF_FFFF;
               load_result = 1'b1;
               state_next  = S_DONE;
            end else if (count == 6'd32) begin
               hi_next     = rem_fix;
               lo_next     = quot_fix;
               load_result = 1'b1;
               state_next  = S_DONE;
            end else begin
               acc_next   = div_step;
               count_next = count + 6'd1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         count     <= 6'd0;
         acc       <= 64'd0;
         is_signed <= 1'b0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         mag_a     <= 32'd0;
         mag_b     <= 32'd0;
         hi_out    <= 32'd0;
         lo_out    <= 32'd0;
      end else if (clk_enable) begin
         state <= state_next;
         count <= count_next;
         acc   <= acc_next;
         if (accept) begin
            is_signed <= ~op[0];
            sign_a    <= a[31];
            sign_b    <= b[31];
            mag_a     <= abs_a;
            mag_b     <= abs_b;
         end
         if (load_result) begin
            hi_out <= hi_next;
            lo_out <= lo_next;
         end
      end
   end

   assign busy            = (state != S_IDLE);
   assign done            = (state == S_DONE);
   assign hi_write_enable = done;
   assign lo_write_enable = done;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit with directed vectors
module tb_mul_div_unit;

`ifdef MUL_DIV_FAST_MULT_EN
   localparam int MUL_LAT   = 1;
   localparam int STALL_LAT = 1;
`else
   localparam int MUL_LAT   = 33;
   localparam int STALL_LAT = 38;
`endif
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0;
   logic        reset, clk_enable, start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done, hi_we, lo_we;
   logic [31:0] hi_out, lo_out;

   mul_div_unit dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
      .op(op), .a(a), .b(b), .busy(busy), .done(done),
      .hi_out(hi_out), .lo_out(lo_out),
      .hi_write_enable(hi_we), .lo_write_enable(lo_we)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          e0;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic last_en   = 1'b1;
   logic prev_done = 1'b0;
   logic mon_on    = 1'b0;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      last_en <= clk_enable;
   end

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per new done pulse
   always @(negedge clk) begin
      if (mon_on) begin
         check("we_pair", {62'd0, hi_we, lo_we}, {62'd0, done, done});
         if (done) begin
            check("done_width", {63'd0, prev_done && last_en}, 64'd0);
            if (!prev_done) begin
               check("expected_pending", {63'd0, sb.size() > 0}, 64'd1);
               if (sb.size() > 0) begin
                  exp_t e;
                  e = sb.pop_front();
                  check({e.name, "_hi"}, {32'd0, hi_out}, {32'd0, e.hi});
                  check({e.name, "_lo"}, {32'd0, lo_out}, {32'd0, e.lo});
                  check({e.name, "_lat"}, 64'(cyc - e.e0), 64'(e.lat));
               end
            end
         end
         prev_done = done;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", {63'd0, busy}, 64'd0);
   endtask

   task automatic issue(string nm, logic [1:0] o, logic [31:0] x, logic [31:0] y,
                        logic [31:0] ehi, logic [31:0] elo, int lat);
      exp_t e;
      wait_idle();
      op = o; a = x; b = y; start = 1'b1;
      e.hi = ehi; e.lo = elo; e.e0 = cyc + 1; e.lat = lat; e.name = nm;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_hi", {32'd0, hi_out}, 64'd0);
      check("rst_lo", {32'd0, lo_out}, 64'd0);
      check("rst_we", {62'd0, hi_we, lo_we}, 64'd0);
      reset = 1'b0;
      mon_on = 1'b1;

      issue("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
      issue("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT);
      issue("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT);
      issue("divu_7_2",  2'b11, 32'd7,         32'd2,         32'd1,         32'd3,         DIV_LAT);
      issue("div_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
      issue("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT);
      issue("divu_z",    2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1);
      issue("div_z_neg", 2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);

      // Stall: second start while busy is ignored, 5 frozen edges extend latency
      issue("mult_stall", 2'b00, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, STALL_LAT);
      repeat (3) @(negedge clk);
`ifndef MUL_DIV_FAST_MULT_EN
      op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
`endif
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      clk_enable = 1'b0;
      repeat (5) @(negedge clk);
      clk_enable = 1'b1;

      // Reset mid-division aborts with zeroed outputs and no done
      wait_idle();
      op = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_hi", {32'd0, hi_out}, 64'd0);
      check("abort_lo", {32'd0, lo_out}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);

      issue("div_after_rst", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, DIV_LAT);
      issue("multu_b2b",     2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, MUL_LAT);

      for (int n = 0; n < 200 && sb.size() > 0; n++) @(negedge clk);
      wait_idle();
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
